// File: rtl/frame_stream_sink.sv
// frame_stream_sink
//   Consumer end of a raster pixel stream. Accepts valid/ready pixels carrying
//   start-of-frame (sof) and end-of-line (eol) markers, recovers the (x,y)
//   raster position and issues frame-buffer writes at address y*HMAX+x. The
//   marker positions are checked. A misplaced sof resynchronises the frame,
//   and framing errors are flagged.
//
//   Optional feature macro: FRAME_SINK_ERRCNT_EN
//     When defined, this adds a saturating 16-bit sync_err counter
//     (err_count) and a synchronous clear input (err_clr).
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   s_valid/s_ready     stream handshake; pixel accepted on s_valid && s_ready
//   s_data/s_sof/s_eol  pixel payload and frame/line markers
//   fb_we/fb_ready      write request (held until fb_ready) / write accept
//   fb_addr/fb_wdata    write address / data
//   hcount/vcount       raster position of the next expected pixel
//   frame_done          pulse with the write of the last pixel of a frame
//   sync_err            pulse with the write of a pixel that broke framing
//   err_count/err_clr   (FRAME_SINK_ERRCNT_EN only) error counter / clear

module frame_stream_sink #(
    parameter int HMAX         = 640,
    parameter int VMAX         = 480,
    parameter int COUNTER_BITS = 11,
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = $clog2(HMAX * VMAX)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_sof,
    input  logic                    s_eol,
    output logic                    fb_we,
    input  logic                    fb_ready,
    output logic [ADDR_W-1:0]       fb_addr,
    output logic [DATA_W-1:0]       fb_wdata,
    output logic [COUNTER_BITS-1:0] hcount,
    output logic [COUNTER_BITS-1:0] vcount,
    output logic                    frame_done,
    output logic                    sync_err
`ifdef FRAME_SINK_ERRCNT_EN
    ,
    output logic [15:0]             err_count,
    input  logic                    err_clr
`endif
);

    localparam logic [COUNTER_BITS-1:0] H_LAST = COUNTER_BITS'(HMAX - 1);
    localparam logic [COUNTER_BITS-1:0] V_LAST = COUNTER_BITS'(VMAX - 1);

    typedef enum logic {
        WAIT_SOF,
        ACTIVE
    } state_t;

    state_t                  state_q, state_d;
    logic [COUNTER_BITS-1:0] hcount_q, hcount_d;
    logic [COUNTER_BITS-1:0] vcount_q, vcount_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;        // address of next expected pixel
    logic                    fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]       fb_addr_q, fb_addr_d;
    logic [DATA_W-1:0]       fb_wdata_q, fb_wdata_d;
    logic                    frame_done_q, frame_done_d;
    logic                    sync_err_q, sync_err_d;

    logic                    accept;
    logic                    resync;
    logic [COUNTER_BITS-1:0] cur_x, cur_y, nxt_x, nxt_y;
    logic [ADDR_W-1:0]       cur_a;
    logic                    x_last, y_last;

    // The single output register can take a new pixel whenever it is empty
    // or is being drained this cycle.
    assign s_ready = !fb_we_q || fb_ready;
    assign accept  = s_valid && s_ready;

    // Position of the pixel being accepted: sof always means (0,0)/addr 0.
    assign cur_x  = s_sof ? '0 : hcount_q;
    assign cur_y  = s_sof ? '0 : vcount_q;
    assign cur_a  = s_sof ? '0 : addr_q;
    assign x_last = (cur_x == H_LAST);
    assign y_last = (cur_y == V_LAST);
    assign nxt_x  = x_last ? '0 : cur_x + 1'b1;
    assign nxt_y  = x_last ? cur_y + 1'b1 : cur_y;

    // A sof anywhere but the expected (0,0) while in a frame is a resync.
    assign resync = s_sof && (state_q == ACTIVE) &&
                    ((hcount_q != '0) || (vcount_q != '0));

    always_comb begin
        state_d      = state_q;
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        addr_d       = addr_q;
        fb_we_d      = fb_we_q;
        fb_addr_d    = fb_addr_q;
        fb_wdata_d   = fb_wdata_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (fb_we_q && fb_ready) begin
            fb_we_d = 1'b0;
        end

        // Pixels accepted while waiting for sof are silently consumed.
        if (accept && (state_q == ACTIVE || s_sof)) begin
            fb_we_d    = 1'b1;
            fb_addr_d  = cur_a;
            fb_wdata_d = s_data;

            if (resync) begin
                // sof rule takes priority; eol is not checked on this pixel.
                sync_err_d = 1'b1;
                state_d    = ACTIVE;
                hcount_d   = nxt_x;
                vcount_d   = nxt_y;
                addr_d     = cur_a + 1'b1;
            end else if (s_eol != x_last) begin
                sync_err_d = 1'b1;
                state_d    = WAIT_SOF;
                hcount_d   = '0;
                vcount_d   = '0;
                addr_d     = '0;
            end else if (x_last && y_last) begin
                frame_done_d = 1'b1;
                state_d      = WAIT_SOF;
                hcount_d     = '0;
                vcount_d     = '0;
                addr_d       = '0;
            end else begin
                state_d  = ACTIVE;
                hcount_d = nxt_x;
                vcount_d = nxt_y;
                addr_d   = cur_a + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_SOF;
            hcount_q     <= '0;
            vcount_q     <= '0;
            addr_q       <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_wdata_q   <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            addr_q       <= addr_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_wdata_q   <= fb_wdata_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_wdata   = fb_wdata_q;
    assign hcount     = hcount_q;
    assign vcount     = vcount_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

`ifdef FRAME_SINK_ERRCNT_EN
    logic [15:0] err_count_q;

    // A clear that coincides with a new error leaves that error counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q <= '0;
        end else if (err_clr) begin
            err_count_q <= sync_err_d ? 16'd1 : 16'd0;
        end else if (sync_err_d && (err_count_q != '1)) begin
            err_count_q <= err_count_q + 16'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_frame_stream_sink.sv
module tb_frame_stream_sink;

    localparam int HMAX   = 4;
    localparam int VMAX   = 3;
    localparam int CB     = 11;
    localparam int DW     = 12;
    localparam int AW     = $clog2(HMAX * VMAX);
    localparam int NCYC_A = 2500;
    localparam int NCYC_B = 2500;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_sof;
    logic          s_eol;
    logic          fb_we;
    logic          fb_ready;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_wdata;
    logic [CB-1:0] hcount;
    logic [CB-1:0] vcount;
    logic          frame_done;
    logic          sync_err;
    logic          err_clr;
`ifdef FRAME_SINK_ERRCNT_EN
    logic [15:0]   err_count;
`endif

    frame_stream_sink #(
        .HMAX        (HMAX),
        .VMAX        (VMAX),
        .COUNTER_BITS(CB),
        .DATA_W      (DW),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .s_eol     (s_eol),
        .fb_we     (fb_we),
        .fb_ready  (fb_ready),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .hcount    (hcount),
        .vcount    (vcount),
        .frame_done(frame_done),
        .sync_err  (sync_err)
`ifdef FRAME_SINK_ERRCNT_EN
        ,
        .err_count (err_count),
        .err_clr   (err_clr)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int addr;
        int data;
        bit done;
        bit err;
    } exp_t;

    exp_t q[$];
    bit   in_frame = 0;
    int   mx = 0, my = 0;
    int   exp_errcnt = 0;

    // Applies the framing rules to one accepted pixel; returns 1 if it errs.
    function automatic bit model_accept(bit sof, bit eol, int d);
        int  x, y;
        bit  err = 0, done = 0;
        exp_t e;
        if (!in_frame && !sof) return 0;
        if (in_frame && sof && (mx != 0 || my != 0)) begin
            e = '{addr: 0, data: d, done: 0, err: 1};
            q.push_back(e);
            mx = 1; my = 0;
            return 1;
        end
        x = sof ? 0 : mx;
        y = sof ? 0 : my;
        if (eol != (x == HMAX - 1))                      err = 1;
        else if (x == HMAX - 1 && y == VMAX - 1)         done = 1;
        e = '{addr: y * HMAX + x, data: d, done: done, err: err};
        q.push_back(e);
        if (err || done) begin
            in_frame = 0; mx = 0; my = 0;
        end else begin
            in_frame = 1;
            if (x + 1 == HMAX) begin mx = 0; my = y + 1; end
            else               begin mx = x + 1; my = y; end
        end
        return err;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    bit   mon_en = 0;
    exp_t cur;

    initial begin
        bit held = 0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (fb_we && !held) begin
                if (q.size() == 0) begin
                    chk("unexpected_write", 32'(fb_addr), 32'hFFFF_FFFF);
                end else begin
                    cur = q.pop_front();
                    chk("wr_addr", 32'(fb_addr), 32'(cur.addr));
                    chk("wr_data", 32'(fb_wdata), 32'(cur.data));
                    chk("frame_done", 32'(frame_done), 32'(cur.done));
                    chk("sync_err", 32'(sync_err), 32'(cur.err));
                end
            end else begin
                if (fb_we) begin
                    chk("stall_addr", 32'(fb_addr), 32'(cur.addr));
                    chk("stall_data", 32'(fb_wdata), 32'(cur.data));
                end
                chk("pulse_idle", {30'd0, frame_done, sync_err}, 32'd0);
            end
            held = fb_we && !fb_ready;
        end
    end

    // ---------------- stimulus ----------------
    bit acc = 0;
    int sx, sy;
    int stall_left = 0;

    task automatic cycle();
        bit e;
        @(negedge clk);
        if (reset) begin
            in_frame = 0; mx = 0; my = 0; exp_errcnt = 0;
            q.delete();
            acc = 0;
        end else begin
            chk("hcount", 32'(hcount), 32'(mx));
            chk("vcount", 32'(vcount), 32'(my));
            chk("s_ready", 32'(s_ready), 32'(!fb_we || fb_ready));
`ifdef FRAME_SINK_ERRCNT_EN
            chk("err_count", 32'(err_count), 32'(exp_errcnt));
`endif
            acc = s_valid && s_ready;
            e = acc ? model_accept(s_sof, s_eol, int'(s_data)) : 1'b0;
            if (err_clr)                        exp_errcnt = e ? 1 : 0;
            else if (e && exp_errcnt != 16'hFFFF) exp_errcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic new_pixel();
        int r;
        s_sof  = (sx == 0 && sy == 0);
        s_eol  = (sx == HMAX - 1);
        s_data = DW'($urandom);
        r = $urandom_range(0, 99);
        if (r < 4)       s_eol = !s_eol;
        else if (r < 7)  s_sof = 1'b1;
        else if (r < 10) s_sof = 1'b0;
        if (sx == HMAX - 1) begin sx = 0; sy = (sy + 1) % VMAX; end
        else sx++;
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            if (!(s_valid && !acc)) begin
                s_valid = ($urandom_range(0, 9) < 8);
                if (s_valid) new_pixel();
            end
            if (stall_left > 0) begin
                fb_ready = 1'b0;
                stall_left--;
            end else if ($urandom_range(0, 14) == 0) begin
                fb_ready   = 1'b0;
                stall_left = $urandom_range(0, 3);
            end else begin
                fb_ready = ($urandom_range(0, 9) != 0);
            end
            err_clr = ($urandom_range(0, 39) == 0);
            cycle();
        end
    endtask

    initial begin
        reset    = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_sof    = 1'b0;
        s_eol    = 1'b0;
        fb_ready = 1'b1;
        err_clr  = 1'b0;
        sx = $urandom_range(0, HMAX - 1);
        sy = $urandom_range(0, VMAX - 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
        chk("rst_hcount", 32'(hcount), 32'd0);
        chk("rst_vcount", 32'(vcount), 32'd0);
        chk("rst_pulses", {30'd0, frame_done, sync_err}, 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd1);
`ifdef FRAME_SINK_ERRCNT_EN
        chk("rst_err_count", 32'(err_count), 32'd0);
`endif
        mon_en = 1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        random_phase(NCYC_A);

        // Reset while a write is stalled drops it.
        s_valid = 1'b0; fb_ready = 1'b1; err_clr = 1'b0; stall_left = 0;
        repeat (3) cycle();
        s_valid = 1'b1; s_sof = 1'b1; s_eol = (HMAX == 1); s_data = DW'($urandom);
        fb_ready = 1'b0;
        cycle();
        s_valid = 1'b0;
        chk("stalled_fb_we", 32'(fb_we), 32'd1);
        reset = 1'b1;
        cycle();
        chk("rstmid_fb_we", 32'(fb_we), 32'd0);
        chk("rstmid_hcount", 32'(hcount), 32'd0);
        chk("rstmid_vcount", 32'(vcount), 32'd0);
        reset = 1'b0;
        fb_ready = 1'b1;

        random_phase(NCYC_B);

        s_valid = 1'b0; fb_ready = 1'b1; err_clr = 1'b0;
        repeat (4) cycle();
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
